// File: rtl/imager_sched_pkg.sv
// Shared types for the imager frame scheduler: one-hot FSM encoding,
// configuration-table address and entry types, and the table pointer step.
package imager_sched_pkg;

    typedef enum logic [5:0] {
        S_EXPOSE  = 6'b000001,
        S_READOUT = 6'b000010,
        S_LOAD    = 6'b000100,
        S_RELEASE = 6'b001000,
        S_HOLD    = 6'b010000,
        S_RESTART = 6'b100000
    } state_t;

    typedef logic [1:0] tbl_addr_t;

    typedef struct packed {
        logic [31:0] exp;
        logic [31:0] pat;
    } tbl_entry_t;

    localparam int unsigned TBL_DEPTH = 4;

    // A pointer sitting at or above the last active entry wraps to 0, so a
    // CFG_LEN that shrinks under the pointer still restarts the sequence.
    function automatic tbl_addr_t next_ptr(input tbl_addr_t ptr, input tbl_addr_t last);
        return (ptr >= last) ? tbl_addr_t'(0) : tbl_addr_t'(ptr + 2'd1);
    endfunction

endpackage

// File: rtl/imager_cfg_table.sv
// 4-entry {exposure, pattern-count} register file: synchronous write,
// registered read, every entry reset to RESET_VAL.
module imager_cfg_table
    import imager_sched_pkg::*;
#(
    parameter tbl_entry_t RESET_VAL = '0
) (
    input  logic       CLKMPRE,
    input  logic       RESET,
    input  logic       wr_en,
    input  tbl_addr_t  wr_addr,
    input  tbl_entry_t wr_data,
    input  tbl_addr_t  rd_addr,
    output tbl_entry_t rd_data
);

    tbl_entry_t mem [TBL_DEPTH];

    // The read samples the array before this cycle's write lands, so a
    // same-cycle write to the addressed entry returns the old value.
    always_ff @(posedge CLKMPRE) begin
        if (RESET) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem[tbl_addr_t'(i)] <= RESET_VAL;
            end
            rd_data <= RESET_VAL;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imager_frame_sched.sv
// Frame-level scheduler for the imager exposure FSM: runs the FSMIND1/FSMIND0
// handshakes, requests ADC readout and steps through the configuration table.
module imager_frame_sched
    import imager_sched_pkg::*;
#(
    parameter logic [31:0] C_EXP_DEFAULT = 32'd10,
    parameter logic [31:0] C_PAT_DEFAULT = 32'd100,
    parameter logic [31:0] C_TIMEOUT     = 32'd50_000_000
) (
    input  logic        CLKMPRE,
    input  logic        RESET,
    input  logic        RUN,
    input  logic [31:0] FRAME_CNT,
    input  logic        CFG_WE,
    input  tbl_addr_t   CFG_ADDR,
    input  logic [31:0] CFG_EXP,
    input  logic [31:0] CFG_PAT,
    input  tbl_addr_t   CFG_LEN,
    output logic [31:0] Exp_subc,
    output logic [31:0] Num_Pat,
    input  logic        FSMIND1,
    output logic        FSMIND1ACK,
    output logic        FSMIND0,
    input  logic        FSMIND0ACK,
    output logic        RO_REQ,
    input  logic        RO_DONE,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] FRAME_IDX,
    output logic        ERR_TIMEOUT,
    output state_t      fsm_state
);

    localparam tbl_entry_t ENTRY_DEFAULT = tbl_entry_t'({C_EXP_DEFAULT, C_PAT_DEFAULT});

    state_t      state_q, state_d;
    tbl_addr_t   ptr_q, ptr_d;
    tbl_addr_t   ld_ptr_q;
    logic [31:0] exp_q, exp_d;
    logic [31:0] pat_q, pat_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] tmo_cnt_q, tmo_d;
    logic        fsmind0_q, fsmind0_d;
    logic        ack_q, ack_d;
    logic        ro_req_q, ro_req_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        run_q;
    logic        last_frame;
    tbl_addr_t   rd_addr;
    tbl_entry_t  rd_entry;

    // The table is read one cycle ahead of the load: the candidate next entry
    // (or entry 0 while parked) is always sitting in rd_entry, and ld_ptr_q
    // remembers which address produced it.
    assign rd_addr = (state_q == S_HOLD || state_q == S_RESTART)
                   ? tbl_addr_t'(0) : next_ptr(ptr_q, CFG_LEN);

    imager_cfg_table #(
        .RESET_VAL (ENTRY_DEFAULT)
    ) u_cfg_table (
        .CLKMPRE (CLKMPRE),
        .RESET   (RESET),
        .wr_en   (CFG_WE),
        .wr_addr (CFG_ADDR),
        .wr_data (tbl_entry_t'({CFG_EXP, CFG_PAT})),
        .rd_addr (rd_addr),
        .rd_data (rd_entry)
    );

    // Handshakes: a request (FSMIND1, RO_REQ, FSMIND0) stays high until its
    // partner responds (FSMIND1ACK, RO_DONE, FSMIND0ACK); the response is
    // sampled on the clock edge and the request drops on the following cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        exp_d      = exp_q;
        pat_d      = pat_q;
        idx_d      = idx_q;
        fsmind0_d  = fsmind0_q;
        ack_d      = ack_q;
        ro_req_d   = ro_req_q;
        err_d      = err_q;
        tmo_d      = tmo_cnt_q;
        last_frame = (FRAME_CNT != 32'd0) && (idx_q + 32'd1 == FRAME_CNT);

        unique case (state_q)
            S_EXPOSE: begin
                if (FSMIND1) begin
                    ack_d    = 1'b1;
                    ro_req_d = 1'b1;
                    state_d  = S_READOUT;
                end
            end
            S_READOUT: begin
                if (RO_DONE) begin
                    ro_req_d = 1'b0;
                    if (!RUN || last_frame) begin
                        state_d = S_HOLD;
                    end else begin
                        idx_d   = idx_q + 32'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                ptr_d     = ld_ptr_q;
                exp_d     = rd_entry.exp;
                pat_d     = rd_entry.pat;
                fsmind0_d = 1'b1;
                state_d   = S_RELEASE;
            end
            S_RELEASE: begin
                if (FSMIND0ACK) begin
                    fsmind0_d = 1'b0;
                    ack_d     = 1'b0;
                    state_d   = S_EXPOSE;
                end
            end
            S_HOLD: begin
                if (RUN && !run_q) begin
                    state_d = S_RESTART;
                end
            end
            S_RESTART: begin
                ptr_d     = '0;
                idx_d     = '0;
                exp_d     = rd_entry.exp;
                pat_d     = rd_entry.pat;
                fsmind0_d = 1'b1;
                state_d   = S_RELEASE;
            end
            default: begin
                state_d = S_EXPOSE;
            end
        endcase

        done_d = (state_d == S_HOLD) && (state_q != S_HOLD);
        busy_d = (state_d != S_HOLD);

        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (state_q == S_EXPOSE || state_q == S_READOUT) begin
            if (tmo_cnt_q != C_TIMEOUT) begin
                tmo_d = tmo_cnt_q + 32'd1;
            end
            if (tmo_d == C_TIMEOUT) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLKMPRE) begin
        if (RESET) begin
            state_q   <= S_EXPOSE;
            ptr_q     <= '0;
            ld_ptr_q  <= '0;
            exp_q     <= C_EXP_DEFAULT;
            pat_q     <= C_PAT_DEFAULT;
            idx_q     <= '0;
            tmo_cnt_q <= '0;
            fsmind0_q <= 1'b0;
            ack_q     <= 1'b0;
            ro_req_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ld_ptr_q  <= rd_addr;
            exp_q     <= exp_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            tmo_cnt_q <= tmo_d;
            fsmind0_q <= fsmind0_d;
            ack_q     <= ack_d;
            ro_req_q  <= ro_req_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            run_q     <= RUN;
        end
    end

    assign Exp_subc    = exp_q;
    assign Num_Pat     = pat_q;
    assign FSMIND1ACK  = ack_q;
    assign FSMIND0     = fsmind0_q;
    assign RO_REQ      = ro_req_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign FRAME_IDX   = idx_q;
    assign ERR_TIMEOUT = err_q;
    assign fsm_state   = state_q;

endmodule
